// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: passes ALU results to writeback and runs one
// request/grant/response data-bus transaction per load or store.
module mem_stage_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_AW-1:0]   in_wd,
  input  logic                in_wreg,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_mem_rd,
  input  logic                in_mem_wr,
  input  logic [1:0]          in_mem_size,
  input  logic                in_mem_sext,
  input  logic [DATA_W-1:0]   in_store_data,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                wb_valid,
  output logic [REG_AW-1:0]   wb_wd,
  output logic                wb_wreg,
  output logic [DATA_W-1:0]   wb_wdata,
  output logic                mis_err,
  output logic [1:0]          o_dbg_state
);

  localparam int MASK_W = DATA_W / 8;

  // Handshake: an op transfers on a clock edge where in_valid & in_ready & ~flush;
  // on the bus, a request transfers on the edge where bus_req & bus_gnt, and the
  // response completes on the first later edge with bus_rvalid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_drop;
  logic [REG_AW-1:0]   r_wd;
  logic                r_wreg;
  logic                r_is_store;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [2:0]          r_offset;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [MASK_W-1:0]   r_bus_wmask;
  logic                r_wb_valid;
  logic [REG_AW-1:0]   r_wb_wd;
  logic                r_wb_wreg;
  logic [DATA_W-1:0]   r_wb_wdata;
  logic                r_mis_err;

  logic                w_accept;
  logic                w_is_mem;
  logic [2:0]          w_offset;
  logic [2:0]          w_align_mask;
  logic                w_misaligned;
  logic [MASK_W-1:0]   w_byte_en;
  logic [DATA_W-1:0]   w_rd_shift;
  logic [DATA_W-1:0]   w_load_data;

  assign in_ready     = (r_state == S_IDLE);
  assign w_accept     = in_valid & in_ready & ~flush;
  assign w_is_mem     = in_mem_rd | in_mem_wr;
  assign w_offset     = in_wdata[2:0];
  assign w_misaligned = |(w_offset & w_align_mask);
  assign w_rd_shift   = bus_rdata >> {r_offset, 3'b000};

  always_comb begin
    w_align_mask = 3'b000;
    w_byte_en    = '0;
    case (in_mem_size)
      2'd0: begin w_align_mask = 3'b000; w_byte_en = MASK_W'(8'h01); end
      2'd1: begin w_align_mask = 3'b001; w_byte_en = MASK_W'(8'h03); end
      2'd2: begin w_align_mask = 3'b011; w_byte_en = MASK_W'(8'h0F); end
      default: begin w_align_mask = 3'b111; w_byte_en = MASK_W'(8'hFF); end
    endcase
  end

  // Lane-aligned load data truncated to the access size, then extended.
  always_comb begin
    w_load_data = w_rd_shift;
    case (r_size)
      2'd0: w_load_data = {{(DATA_W-8){r_sext & w_rd_shift[7]}}, w_rd_shift[7:0]};
      2'd1: w_load_data = {{(DATA_W-16){r_sext & w_rd_shift[15]}}, w_rd_shift[15:0]};
      2'd2: w_load_data = {{(DATA_W-32){r_sext & w_rd_shift[31]}}, w_rd_shift[31:0]};
      default: w_load_data = w_rd_shift;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mem && !w_misaligned) w_state_nxt = S_REQ;
      S_REQ: begin
        if (bus_gnt)    w_state_nxt = S_RESP;
        else if (flush) w_state_nxt = S_IDLE;
      end
      S_RESP: if (bus_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop      <= 1'b0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_is_store  <= 1'b0;
      r_size      <= 2'd0;
      r_sext      <= 1'b0;
      r_offset    <= 3'd0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wmask <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_wd     <= '0;
      r_wb_wreg   <= 1'b0;
      r_wb_wdata  <= '0;
      r_mis_err   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_mis_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_is_mem) begin
            r_wb_valid <= 1'b1;
            r_wb_wd    <= in_wd;
            r_wb_wreg  <= in_wreg;
            r_wb_wdata <= in_wdata;
          end else if (w_accept && w_misaligned) begin
            r_wb_valid <= 1'b1;
            r_mis_err  <= 1'b1;
            r_wb_wd    <= in_wd;
            r_wb_wreg  <= 1'b0;
            r_wb_wdata <= '0;
          end else if (w_accept) begin
            r_drop      <= 1'b0;
            r_wd        <= in_wd;
            r_wreg      <= in_wreg;
            r_is_store  <= in_mem_wr;
            r_size      <= in_mem_size;
            r_sext      <= in_mem_sext;
            r_offset    <= w_offset;
            r_bus_we    <= in_mem_wr;
            r_bus_addr  <= {in_wdata[ADDR_W-1:3], 3'b000};
            r_bus_wdata <= in_store_data << {w_offset, 3'b000};
            r_bus_wmask <= w_byte_en << w_offset;
          end
        end
        S_REQ: if (bus_gnt && flush) r_drop <= 1'b1;
        S_RESP: begin
          if (flush) r_drop <= 1'b1;
          // A killed transaction still has to drain, but leaves wb_* untouched.
          if (bus_rvalid && !(r_drop || flush)) begin
            r_wb_valid <= 1'b1;
            r_wb_wd    <= r_wd;
            r_wb_wreg  <= r_is_store ? 1'b0 : r_wreg;
            r_wb_wdata <= r_is_store ? '0 : w_load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req     = (r_state == S_REQ);
  assign bus_we      = r_bus_we;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_wmask   = r_bus_wmask;
  assign wb_valid    = r_wb_valid;
  assign wb_wd       = r_wb_wd;
  assign wb_wreg     = r_wb_wreg;
  assign wb_wdata    = r_wb_wdata;
  assign mis_err     = r_mis_err;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage sequencer that sits downstream of the ALU→MEM pipeline register.
- Accepts one ALU/MEM operation at a time and passes non-memory results straight to writeback.
- For loads and stores, runs a request/grant/response transaction on the data bus, aligns and extends load data, and holds off upstream until the access completes.
- Produces the single registered writeback packet for the register file.

Parameters:
- DATA_W, 64, data/register width (RegBus)
- ADDR_W, 64, bus address width
- REG_AW, 5, register address width (RegAddrBus)

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  kill in-flight/incoming op (branch/trap redirect)
- in_valid  input  1  op from ALU→MEM register valid
- in_ready  output  1  block can accept op this cycle
- in_wd  input  REG_AW  destination register
- in_wreg  input  1  op writes register
- in_wdata  input  DATA_W  ALU result; effective address when memory op
- in_mem_rd  input  1  load
- in_mem_wr  input  1  store (in_mem_rd and in_mem_wr never both 1)
- in_mem_size  input  2  0=B, 1=H, 2=W, 3=D
- in_mem_sext  input  1  sign-extend load
- in_store_data  input  DATA_W  store data, right-aligned
- bus_req  output  1  access request
- bus_we  output  1  1=store
- bus_addr  output  ADDR_W  8-byte-aligned address
- bus_wdata  output  DATA_W  lane-shifted store data
- bus_wmask  output  DATA_W/8  byte enables
- bus_gnt  input  1  request accepted
- bus_rvalid  input  1  response (load data valid / store ack)
- bus_rdata  input  DATA_W  load data, full 8-byte word
- wb_valid  output  1  writeback packet valid, one-cycle pulse
- wb_wd  output  REG_AW  writeback register
- wb_wreg  output  1  write enable
- wb_wdata  output  DATA_W  writeback data
- mis_err  output  1  one-cycle pulse: misaligned access dropped

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State to IDLE.
  - All outputs 0, except in_ready=1.
  - wb_wd = 0 (NOP register).
  - An in-flight bus transaction is abandoned. The bus side must also be reset.
- States: IDLE, REQ, RESP.
- in_ready = 1 only in IDLE. Acceptance = in_valid & in_ready & ~flush.
- IDLE, accepting a non-memory op:
  - Next cycle: wb_valid=1, wb_wd/wb_wreg/wb_wdata = in_wd/in_wreg/in_wdata.
  - Latency is 1 cycle. Back-to-back ops are accepted every cycle.
- IDLE, accepting a memory op:
  - Latch the op; offset = addr[2:0]; bytes = 1<<size.
  - Misaligned when offset mod bytes ≠ 0. In that case, next cycle: mis_err=1, wb_valid=1, wb_wreg=0. No bus access; stay in IDLE.
  - Otherwise go to REQ.
- REQ:
  - bus_req=1, bus_we = store, bus_addr = {addr[ADDR_W-1:3],3'b0}.
  - bus_wdata = store_data << 8*offset.
  - bus_wmask = ((1<<bytes)-1) << offset.
  - All bus outputs stay stable until bus_gnt. bus_gnt sampled high → RESP, bus_req drops next cycle.
  - flush while in REQ with bus_gnt=0: return to IDLE with no writeback.
  - flush in the same cycle as bus_gnt: transaction proceeds, drop flag set.
- RESP:
  - bus_req=0. Wait for bus_rvalid (a response in the grant cycle is not legal).
  - On bus_rvalid, next cycle: wb_valid=1, wb_wd = latched wd.
  - Load: wb_wreg = latched wreg; wb_wdata = (bus_rdata >> 8*offset) truncated to bytes, then sign- or zero-extended per sext. Size 3 passes the word unchanged.
  - Store: wb_wreg=0, wb_wdata=0.
  - Then return to IDLE.
- flush in RESP: keep waiting for bus_rvalid (the bus transaction must finish). Set the drop flag; the completion then yields wb_valid=0.
- flush in IDLE: the incoming op is discarded. A wb_valid already being registered this cycle from a prior accept still fires.
- wb_valid is a single-cycle pulse. wb_* fields hold their last value while wb_valid=0.
- No wait-cycle limit: an unanswered bus stalls indefinitely.

Test Plan:
- Non-memory op: in_valid with wd=5, wreg=1, wdata=0x1234, mem flags 0 → next cycle wb_valid=1, wb_wd=5, wb_wdata=0x1234. Three back-to-back ops → three consecutive wb pulses.
- Signed byte load:
  - Stimulus: addr=0x8000_0003, size=0, sext=1, wd=7; gnt 2 cycles after req; rvalid 3 cycles later; rdata=0x0000_0000_8000_0000.
  - Required: bus_addr=0x8000_0000; in_ready=0 throughout; wb_wdata=0xFFFF_FFFF_FFFF_FF80, wb_wd=7, one cycle after rvalid.
- Halfword store:
  - Stimulus: addr=0x8000_0006, size=1, store_data=0xBEEF.
  - Required: bus_we=1, bus_wmask=0xC0, bus_wdata=0xBEEF_0000_0000_0000.
  - After rvalid: wb_valid=1, wb_wreg=0.
- Misaligned: word load at addr=0x8000_0002 → no bus_req; next cycle mis_err=1, wb_valid=1, wb_wreg=0.
- Flush:
  - flush in REQ before gnt → bus_req drops next cycle, no wb_valid, in_ready=1.
  - flush in RESP → state held until rvalid, then wb_valid stays 0.
- Reset mid-RESP: rst_n=0 for one cycle → next cycle bus_req=0, wb_valid=0, in_ready=1; a new op completes normally.
